// File: rtl/max6675_scan_scheduler.sv
// Purpose: time-shares one SPI master across NUM_SENSORS MAX6675 converters and publishes decoded frames.
// Latency: first byte request CS_SETUP_CLKS+1 cycles after the period tick; result valid the cycle after the last byte.
// Backpressure: one result outstanding; the FSM stalls in CS_GAP (CS high) until the consumer accepts it.
module max6675_scan_scheduler #(
    parameter int NUM_SENSORS   = 4,
    parameter int SENSOR_ID_W   = 2,
    parameter int CLKS_PER_CONV = 22000000,
    parameter int CS_SETUP_CLKS = 10,
    parameter int CS_HOLD_CLKS  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_SENSORS-1:0] i_enable,
    output logic [NUM_SENSORS-1:0] o_cs_n,
    output logic                   o_spi_tx_dv,
    input  logic                   i_spi_tx_ready,
    input  logic                   i_spi_rx_dv,
    input  logic [7:0]             i_spi_rx_byte,
    output logic                   o_result_valid,
    input  logic                   i_result_ready,
    output logic [SENSOR_ID_W-1:0] o_result_id,
    output logic [11:0]            o_result_temp,
    output logic                   o_result_open,
    output logic                   o_result_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam int PER_W = (CLKS_PER_CONV > 1) ? $clog2(CLKS_PER_CONV) : 1;
    localparam int SET_W = $clog2(CS_SETUP_CLKS + 1);
    localparam int HLD_W = $clog2(CS_HOLD_CLKS + 1);
    localparam int DLY_W = (SET_W > HLD_W) ? SET_W : HLD_W;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        BYTE_REQ,
        BYTE_WAIT,
        PUBLISH,
        CS_GAP
    } state_t;

    state_t                 state;
    logic [PER_W-1:0]       per_cnt;
    logic                   tick;
    logic [NUM_SENSORS-1:0] mask;
    logic [SENSOR_ID_W-1:0] idx;
    logic [DLY_W-1:0]       dly_cnt;
    logic                   byte_cnt;
    logic [7:0]             frame_hi;
    logic [SENSOR_ID_W:0]   first_pick;
    logic [SENSOR_ID_W:0]   next_pick;

    // Lowest set bit of m at or above position 'from'; MSB of the result flags "found".
    function automatic logic [SENSOR_ID_W:0] pick_from(input logic [NUM_SENSORS-1:0] m, input int from);
        logic [SENSOR_ID_W:0] r;
        r = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = {1'b1, SENSOR_ID_W'(i)};
            end
        end
        return r;
    endfunction

    // Active-low one-cold chip select for sensor id.
    function automatic logic [NUM_SENSORS-1:0] cs_for(input logic [SENSOR_ID_W-1:0] id);
        logic [NUM_SENSORS-1:0] c;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            c[i] = (id != SENSOR_ID_W'(i));
        end
        return c;
    endfunction

    assign tick   = (per_cnt == PER_W'(CLKS_PER_CONV - 1));
    assign o_busy = (state != IDLE);

    // First sensor of a new sweep comes straight from the live enable mask.
    always_comb begin
        first_pick = pick_from(i_enable, 0);
    end

    // Next sensor within the current sweep comes from the latched mask.
    always_comb begin
        next_pick = pick_from(mask, int'(idx) + 1);
    end

    // Free-running conversion period counter; wraps on the tick cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            per_cnt <= '0;
        end else if (tick) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // Sweep sequencer; outputs are registered and change on the edge entering each state.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state          <= IDLE;
            mask           <= '0;
            idx            <= '0;
            dly_cnt        <= '0;
            byte_cnt       <= 1'b0;
            frame_hi       <= '0;
            o_cs_n         <= '1;
            o_spi_tx_dv    <= 1'b0;
            o_result_valid <= 1'b0;
            o_result_id    <= '0;
            o_result_temp  <= '0;
            o_result_open  <= 1'b0;
            o_result_err   <= 1'b0;
            o_overrun      <= 1'b0;
        end else begin
            o_spi_tx_dv <= 1'b0;
            // A tick that lands mid-sweep is reported and dropped, never queued.
            o_overrun   <= tick && (state != IDLE);
            if (o_result_valid && i_result_ready) begin
                o_result_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        mask <= i_enable;
                        if (first_pick[SENSOR_ID_W]) begin
                            idx     <= first_pick[SENSOR_ID_W-1:0];
                            o_cs_n  <= cs_for(first_pick[SENSOR_ID_W-1:0]);
                            dly_cnt <= '0;
                            state   <= CS_SETUP;
                        end
                    end
                end

                CS_SETUP: begin
                    if (dly_cnt == DLY_W'(CS_SETUP_CLKS - 1)) begin
                        byte_cnt <= 1'b0;
                        state    <= BYTE_REQ;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end

                BYTE_REQ: begin
                    if (i_spi_tx_ready) begin
                        o_spi_tx_dv <= 1'b1;
                        state       <= BYTE_WAIT;
                    end
                end

                BYTE_WAIT: begin
                    if (i_spi_rx_dv) begin
                        if (!byte_cnt) begin
                            frame_hi <= i_spi_rx_byte;
                            byte_cnt <= 1'b1;
                            state    <= BYTE_REQ;
                        end else begin
                            // Raising CS here starts the device's next conversion.
                            o_cs_n         <= '1;
                            o_result_valid <= 1'b1;
                            o_result_id    <= idx;
                            o_result_temp  <= {frame_hi[6:0], i_spi_rx_byte[7:3]};
                            o_result_open  <= i_spi_rx_byte[2];
                            o_result_err   <= frame_hi[7] | i_spi_rx_byte[1];
                            state          <= PUBLISH;
                        end
                    end
                end

                PUBLISH: begin
                    dly_cnt <= '0;
                    state   <= CS_GAP;
                end

                CS_GAP: begin
                    if (dly_cnt != DLY_W'(CS_HOLD_CLKS - 1)) begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end else if (!o_result_valid) begin
                        if (next_pick[SENSOR_ID_W]) begin
                            idx     <= next_pick[SENSOR_ID_W-1:0];
                            o_cs_n  <= cs_for(next_pick[SENSOR_ID_W-1:0]);
                            dly_cnt <= '0;
                            state   <= CS_SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max6675_scan_scheduler.sv
// Purpose: self-checking bench for max6675_scan_scheduler with a behavioural SPI/MAX6675 model.
// Latency: expected results are queued per sweep and compared as the consumer accepts them.
// Backpressure: consumer ready is driven by the stimulus; one case holds it low to force a CS_GAP stall.
module tb_max6675_scan_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  enable;
    logic [3:0]  cs_n;
    logic        tx_dv;
    logic        tx_ready;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [11:0] res_temp;
    logic        res_open;
    logic        res_err;
    logic        overrun;
    logic        busy;

    max6675_scan_scheduler #(
        .NUM_SENSORS  (4),
        .SENSOR_ID_W  (2),
        .CLKS_PER_CONV(200),
        .CS_SETUP_CLKS(4),
        .CS_HOLD_CLKS (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_enable      (enable),
        .o_cs_n        (cs_n),
        .o_spi_tx_dv   (tx_dv),
        .i_spi_tx_ready(tx_ready),
        .i_spi_rx_dv   (rx_dv),
        .i_spi_rx_byte (rx_byte),
        .o_result_valid(res_valid),
        .i_result_ready(res_ready),
        .o_result_id   (res_id),
        .o_result_temp (res_temp),
        .o_result_open (res_open),
        .o_result_err  (res_err),
        .o_overrun     (overrun),
        .o_busy        (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] frames[4];
    int          rx_delay;

    // Monitor state
    int          cyc = 0;
    int          cs_viol = 0;
    logic [3:0]  cs_prev = 4'hF;
    logic [3:0]  cs_log[$];
    int          n_csfall = 0;
    int          fall_cyc = 0;
    bit          tx_first = 0;
    int          tx_lat = -1;
    int          n_tx = 0;
    int          rx_cyc = 0;
    int          valid_lat = -1;
    logic        valid_prev = 1'b0;
    int          busy_cyc = 0;
    int          n_overrun = 0;
    int          n_results = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_results(input int target, input int budget, input string tag);
        int n = 0;
        while (n_results < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(tag, n_results >= target, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_falls(input int target, input int budget, input string tag);
        int n = 0;
        while (n_csfall < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(tag, n_csfall >= target, 1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SPI master + MAX6675 model: answers each byte request after rx_delay cycles.
    initial begin
        int   sid;
        logic byte_sel;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        byte_sel = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cs_n == 4'hF) byte_sel = 1'b0;
            if (tx_dv) begin
                sid = 0;
                for (int i = 3; i >= 0; i--) if (!cs_n[i]) sid = i;
                repeat (rx_delay) begin @(posedge clk); #1; end
                rx_byte  = byte_sel ? frames[sid][7:0] : frames[sid][15:8];
                byte_sel = ~byte_sel;
                rx_dv    = 1'b1;
                @(posedge clk); #1;
                rx_dv    = 1'b0;
            end
        end
    end

    // Monitor and scoreboard consumer, sampled on the falling edge.
    initial begin
        logic [15:0] e;
        int zeros;
        forever begin
            @(negedge clk);
            cyc++;
            zeros = 0;
            for (int i = 0; i < 4; i++) if (cs_n[i] === 1'b0) zeros++;
            if (zeros > 1) cs_viol++;
            if (cs_n !== cs_prev && rst_n) begin
                cs_log.push_back(cs_n);
                if (cs_n != 4'hF && cs_prev == 4'hF) begin
                    n_csfall++;
                    fall_cyc = cyc;
                    tx_first = 1;
                end
                cs_prev = cs_n;
            end
            if (tx_dv === 1'b1) begin
                n_tx++;
                if (tx_first) begin
                    tx_lat   = cyc - fall_cyc;
                    tx_first = 0;
                end
            end
            if (rx_dv) rx_cyc = cyc;
            if (res_valid === 1'b1 && !valid_prev) valid_lat = cyc - rx_cyc;
            valid_prev = (res_valid === 1'b1);
            if (busy === 1'b1) busy_cyc++;
            if (overrun === 1'b1) n_overrun++;
            if (res_valid === 1'b1 && res_ready) begin
                n_results++;
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", {res_id, res_temp, res_open, res_err}, e);
                end
            end
        end
    end

    initial begin
        int base_r, base_f, base_tx, base_b, ov0, t0, t1, k, unstable, cs_bad;
        logic [15:0] snap;

        rst_n     = 1'b0;
        enable    = 4'h0;
        tx_ready  = 1'b1;
        res_ready = 1'b1;
        rx_delay  = 3;
        frames[0] = 16'h0C80;
        frames[1] = 16'h07D2;
        frames[2] = 16'h1904;
        frames[3] = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_valid", res_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_fields", {res_id, res_temp, res_open, res_err}, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: two sensors, normal decode, CS sequence and latencies
        cs_log.delete();
        base_r = n_results;
        base_tx = n_tx;
        enable = 4'b0101;
        exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
        exp_q.push_back({2'd2, 12'h320, 1'b1, 1'b0});
        wait_results(base_r + 2, 600, "t1_results");
        wait_idle(100, "t1_idle");
        enable = 4'b0000;
        check("t1_queue", exp_q.size(), 0);
        check("t1_cs_log_len", cs_log.size(), 4);
        check("t1_cs_seq", {cs_log[0], cs_log[1], cs_log[2], cs_log[3]}, 16'hEFBF);
        check("t1_tx_count", n_tx - base_tx, 4);
        check("t1_tx_latency", tx_lat, 5);
        check("t1_valid_latency", valid_lat, 1);

        // 2: stuck-high MISO on sensor 1
        frames[1] = 16'hFFFF;
        base_r = n_results;
        enable = 4'b0010;
        exp_q.push_back({2'd1, 12'hFFF, 1'b1, 1'b1});
        wait_results(base_r + 1, 600, "t2_results");
        wait_idle(100, "t2_idle");
        enable = 4'b0000;
        check("t2_queue", exp_q.size(), 0);

        // 3: consumer backpressure stalls the sweep with CS high
        frames[1] = 16'h07D2;
        base_r = n_results;
        res_ready = 1'b0;
        enable = 4'b0011;
        exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
        exp_q.push_back({2'd1, 12'h0FA, 1'b0, 1'b1});
        k = 0;
        @(negedge clk);
        while (res_valid !== 1'b1 && k < 600) begin @(negedge clk); k++; end
        check("t3_first_valid", res_valid, 1);
        snap = {res_id, res_temp, res_open, res_err};
        unstable = 0;
        cs_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || {res_id, res_temp, res_open, res_err} !== snap) unstable++;
            if (cs_n !== 4'hF) cs_bad++;
        end
        check("t3_hold_stable", unstable, 0);
        check("t3_cs_high_stall", cs_bad, 0);
        check("t3_no_accept_yet", n_results - base_r, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_results(base_r + 2, 600, "t3_results");
        wait_idle(100, "t3_idle");
        enable = 4'b0000;
        repeat (5) @(posedge clk);
        #1;
        check("t3_result_total", n_results - base_r, 2);

        // 4: slow SPI makes the sweep overrun the period
        base_r = n_results;
        base_f = n_csfall;
        ov0 = n_overrun;
        rx_delay = 60;
        enable = 4'b0101;
        repeat (2) begin
            exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
            exp_q.push_back({2'd2, 12'h320, 1'b1, 1'b0});
        end
        wait_falls(base_f + 1, 400, "t4_sweep1_start");
        t0 = fall_cyc;
        wait_idle(500, "t4_sweep1_end");
        rx_delay = 3;
        wait_falls(base_f + 3, 400, "t4_sweep2_start");
        t1 = fall_cyc;
        check("t4_sweep_spacing", t1 - t0, 400);
        check("t4_overrun_count", n_overrun - ov0, 1);
        wait_results(base_r + 4, 600, "t4_results");
        wait_idle(100, "t4_idle");
        enable = 4'b0000;

        // 5: reset in BYTE_WAIT abandons the frame and restarts the period
        rx_delay = 20;
        enable = 4'b0001;
        exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
        k = 0;
        while (tx_dv !== 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
        check("t5_tx_seen", tx_dv, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_cs_n", cs_n, 4'hF);
        check("t5_rst_tx_dv", tx_dv, 0);
        check("t5_rst_valid", res_valid, 0);
        check("t5_rst_busy", busy, 0);
        rst_n = 1'b1;
        rx_delay = 3;
        exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
        base_r = n_results;
        k = 0;
        while (cs_n === 4'hF && k < 400) begin @(negedge clk); k++; end
        check("t5_restart_delay", k, 200);
        wait_results(base_r + 1, 400, "t5_results");
        wait_idle(100, "t5_idle");
        enable = 4'b0000;

        // 6: empty mask does nothing; enable change mid-sweep is ignored
        base_f = n_csfall;
        base_tx = n_tx;
        base_b = busy_cyc;
        repeat (250) @(posedge clk);
        #1;
        check("t6_no_cs", n_csfall - base_f, 0);
        check("t6_no_tx", n_tx - base_tx, 0);
        check("t6_no_busy", busy_cyc - base_b, 0);
        base_r = n_results;
        enable = 4'b0001;
        exp_q.push_back({2'd0, 12'h190, 1'b0, 1'b0});
        wait_falls(base_f + 1, 300, "t6_sweep_start");
        enable = 4'b1111;
        wait_idle(300, "t6_idle");
        enable = 4'b0000;
        wait_results(base_r + 1, 100, "t6_results");
        check("t6_one_frame", n_csfall - base_f, 1);
        check("t6_one_result", n_results - base_r, 1);

        check("queue_empty", exp_q.size(), 0);
        check("cs_onehot", cs_viol, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/max6675_scan_scheduler.md
Name: max6675_scan_scheduler

Overview:
Sequences one shared SPI_Master instance across NUM_SENSORS MAX6675 thermocouple converters.
- Paces reads at the converter's conversion period.
- Drives a one-hot active-low chip select per sensor.
- Issues the two SPI byte transfers per frame and assembles the 16-bit frame.
- Decodes temperature, open-thermocouple and frame-error fields.
- Hands each result to a downstream consumer (e.g. UART packer) with valid/ready.

Parameters:
NUM_SENSORS, 4, number of MAX6675 devices on the shared SCK/MISO
SENSOR_ID_W, 2, width of sensor index; must satisfy 2**SENSOR_ID_W >= NUM_SENSORS
CLKS_PER_CONV, 22000000, i_clk cycles between sweep starts (220 ms at 100 MHz)
CS_SETUP_CLKS, 10, cycles CS held low before the first byte request
CS_HOLD_CLKS, 10, minimum cycles CS held high between consecutive sensor frames

Ports:
i_clk  in  1  system clock, 100 MHz
i_reset  in  1  synchronous active-low reset
i_enable  in  NUM_SENSORS  per-sensor scan enable mask, sampled at sweep start
o_cs_n  out  NUM_SENSORS  active-low chip selects, at most one bit low
o_spi_tx_dv  out  1  one-cycle byte-transfer request to SPI master
i_spi_tx_ready  in  1  SPI master idle/ready
i_spi_rx_dv  in  1  one-cycle pulse, received byte valid
i_spi_rx_byte  in  8  received byte
o_result_valid  out  1  result available, held until accepted
i_result_ready  in  1  consumer accepts result when high with valid
o_result_id  out  SENSOR_ID_W  sensor index of the result
o_result_temp  out  12  frame[14:3], 0.25 degC/LSB
o_result_open  out  1  frame[2], thermocouple open
o_result_err  out  1  frame[15] or frame[1] set (bad frame / MISO stuck)
o_overrun  out  1  one-cycle pulse: period tick while sweep still active
o_busy  out  1  high when FSM is not in IDLE

Behaviour:
- Reset (i_reset low at posedge), regardless of state:
  - o_cs_n all ones; o_spi_tx_dv, o_result_valid and o_overrun 0; result fields 0.
  - FSM to IDLE; period counter 0.
  - A frame in flight is abandoned; the SPI master's own reset is its concern.
- Period counter: free-running 0..CLKS_PER_CONV-1. Tick is the cycle the counter equals CLKS_PER_CONV-1; the counter wraps to 0 on that cycle.
- FSM states:
  - IDLE, on tick:
    - Latch i_enable into the sweep mask.
    - Mask zero: stay in IDLE.
    - Otherwise: select the lowest set index and go to CS_SETUP.
  - CS_SETUP: o_cs_n[idx] low; count CS_SETUP_CLKS cycles, clear the byte counter, then go to BYTE_REQ.
  - BYTE_REQ: wait for i_spi_tx_ready=1, then assert o_spi_tx_dv for exactly 1 cycle and go to BYTE_WAIT.
  - BYTE_WAIT: on i_spi_rx_dv, shift the byte in (first byte is frame[15:8], second is frame[7:0]).
    - After byte 0: go to BYTE_REQ.
    - After byte 1: go to PUBLISH.
  - PUBLISH:
    - o_cs_n all high (CS rising edge restarts conversion in the device).
    - Load result fields and set o_result_valid.
    - Go to CS_GAP.
  - CS_GAP: count CS_HOLD_CLKS cycles with CS high.
    - If o_result_valid is still 1, stall here until it clears.
    - Then select the next set mask bit above idx: go to CS_SETUP, or to IDLE if none remain.
- Result handshake:
  - valid and fields hold stable until a cycle with valid and ready both 1; valid clears on the following edge.
  - ready while valid=0 has no effect.
  - Never more than one result outstanding; CS_GAP stall enforces this.
- Overrun: a tick while FSM != IDLE pulses o_overrun for 1 cycle and is otherwise dropped (no queued sweep).
- Latency: the first o_spi_tx_dv occurs CS_SETUP_CLKS+1 cycles after the tick edge (given i_spi_tx_ready already 1). o_result_valid rises the cycle after the second i_spi_rx_dv.
- i_enable changes mid-sweep have no effect until the next sweep.
- i_spi_rx_dv outside BYTE_WAIT is ignored.
- o_busy = (state != IDLE).

Test Plan:
1. Params CLKS_PER_CONV=200, CS_SETUP_CLKS=4, CS_HOLD_CLKS=4, i_enable=4'b0101, SPI model returns 0x0C80 for sensor 0 and 0x1904 for sensor 2, ready tied 1.
   - Required: results id0/temp=0x190/open=0/err=0, then id2/temp=0x320/open=1/err=0.
   - Required: o_cs_n shows 1110 then 1011; never two bits low.
2. Sensor 1 only, model returns 0xFFFF -> o_result_err=1, temp=0xFFF, open=1.
3. i_result_ready held 0 for 50 cycles after first valid, enable=4'b0011 -> valid and fields stable for all 50 cycles; sensor 1 CS stays high until the accept; exactly two results total.
4. SPI model delays rx_dv so the sweep spans more than 200 cycles -> o_overrun pulses once at the tick; no restart mid-sweep; next sweep begins at the following tick.
5. Assert i_reset low during BYTE_WAIT of sensor 0 -> next edge: o_cs_n=4'b1111, o_spi_tx_dv=0, o_result_valid=0, o_busy=0; after release, the first sweep starts 200 cycles later.
6. i_enable=0 at tick -> no CS activity, no tx_dv, o_busy stays 0; changing i_enable mid-sweep does not alter the current sweep.
